// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;
    localparam int MAX_WORDS  = 1 << ADDR_W_DEF;

    typedef enum logic [2:0] {
        ST_CNT_HI,
        ST_CNT_LO,
        ST_DAT_HI,
        ST_DAT_LO,
        ST_CHK,
        ST_DONE,
        ST_ERROR
    } state_t;

    function automatic logic [15:0] max_words(input int aw);
        return 16'(1 << aw);
    endfunction

endpackage

// File: rtl/loader_mem_mux.sv
// RAM port mux: loader owns the port while loading, CPU owns it once released.
module loader_mem_mux #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              sel_cpu,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    input  logic              cpu_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we
);

    assign mem_addr = sel_cpu ? cpu_addr : ld_addr;
    assign mem_data = sel_cpu ? cpu_data : ld_data;
    assign mem_we   = sel_cpu ? cpu_we   : ld_we;

endmodule

// File: rtl/program_loader.sv
// Boot loader: byte stream -> big-endian words -> program RAM, then releases the CPU.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic [15:0]       cpu_Address,
    input  logic [15:0]       cpu_D_out,
    input  logic              cpu_mw_en,
    output logic [ADDR_W-1:0] mem_Address,
    output logic [15:0]       mem_D_in,
    output logic              mem_we,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [15:0] MAX_N = max_words(ADDR_W);

`ifdef LOADER_CHECKSUM_EN
    localparam state_t AFTER_DATA = ST_CHK;
    logic [7:0] csum;
`else
    localparam state_t AFTER_DATA = ST_DONE;
`endif

    state_t            state, state_next;
    logic [7:0]        count_hi;
    logic [7:0]        hi_byte;
    logic [15:0]       count;
    logic [ADDR_W:0]   ptr;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_we;
    logic [15:0]       n_word;
    logic              last_word;
    logic              cpu_sel;
    logic              unused_addr_bits;

    assign n_word           = {count_hi, rx_data};
    assign last_word        = (16'(ptr) + 16'd1) == count;
    assign unused_addr_bits = ^cpu_Address[15:ADDR_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_CNT_HI;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (rx_valid) begin
            case (state)
                ST_CNT_HI: state_next = ST_CNT_LO;
                ST_CNT_LO: begin
                    if (n_word == 16'd0)    state_next = AFTER_DATA;
                    else if (n_word > MAX_N) state_next = ST_ERROR;
                    else                    state_next = ST_DAT_HI;
                end
                ST_DAT_HI: state_next = ST_DAT_LO;
                ST_DAT_LO: state_next = last_word ? AFTER_DATA : ST_DAT_HI;
`ifdef LOADER_CHECKSUM_EN
                ST_CHK:    state_next = (rx_data == csum) ? ST_DONE : ST_ERROR;
`endif
                default:   state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_hi <= '0;
            hi_byte  <= '0;
            count    <= '0;
            ptr      <= '0;
            ld_addr  <= '0;
            ld_data  <= '0;
            ld_we    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            ld_we <= 1'b0;
            if (rx_valid) begin
                case (state)
                    ST_CNT_HI: count_hi <= rx_data;
                    ST_CNT_LO: count    <= n_word;
                    ST_DAT_HI: hi_byte  <= rx_data;
                    ST_DAT_LO: begin
                        ld_we   <= 1'b1;
                        ld_addr <= ptr[ADDR_W-1:0];
                        ld_data <= DATA_W'({hi_byte, rx_data});
                        ptr     <= ptr + 1'b1;
                    end
                    default: ;
                endcase
`ifdef LOADER_CHECKSUM_EN
                if (state inside {ST_CNT_HI, ST_CNT_LO, ST_DAT_HI, ST_DAT_LO})
                    csum <= csum ^ rx_data;
`endif
            end
        end
    end

    assign done      = (state == ST_DONE);
    assign error     = (state == ST_ERROR);
    assign busy      = !(done || error);
    assign cpu_reset = !done;

    // The final data write lands in the first DONE cycle; it keeps the port for that cycle.
    assign cpu_sel = done && !ld_we;

    loader_mem_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem_mux (
        .sel_cpu  (cpu_sel),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .ld_we    (ld_we),
        .cpu_addr (cpu_Address[ADDR_W-1:0]),
        .cpu_data (cpu_D_out),
        .cpu_we   (cpu_mw_en),
        .mem_addr (mem_Address),
        .mem_data (mem_D_in),
        .mem_we   (mem_we)
    );

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader; covers the checksum frame when LOADER_CHECKSUM_EN is defined.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic [15:0] cpu_Address = '0;
    logic [15:0] cpu_D_out = '0;
    logic        cpu_mw_en = 1'b0;
    logic [7:0]  mem_Address;
    logic [15:0] mem_D_in;
    logic        mem_we;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0]  wr_addr[$];
    logic [15:0] wr_data[$];
    logic [15:0] ram[256];

    always #5 clk = ~clk;

    program_loader dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .cpu_Address (cpu_Address),
        .cpu_D_out   (cpu_D_out),
        .cpu_mw_en   (cpu_mw_en),
        .mem_Address (mem_Address),
        .mem_D_in    (mem_D_in),
        .mem_we      (mem_we),
        .cpu_reset   (cpu_reset),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    // RAM model: captures whatever the port writes, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(mem_Address);
            wr_data.push_back(mem_D_in);
            ram[mem_Address] = mem_D_in;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wr_addr.delete();
        wr_data.delete();
    endtask

    initial begin
        logic [7:0] ck;

        // Reset values
        @(negedge clk);
        check("rst_addr", 32'(mem_Address), 32'h0);
        check("rst_data", 32'(mem_D_in), 32'h0);
        check("rst_we", 32'(mem_we), 32'h0);
        check("rst_cpu_reset", 32'(cpu_reset), 32'h1);
        check("rst_busy", 32'(busy), 32'h1);
        check("rst_done", 32'(done), 32'h0);
        check("rst_error", 32'(error), 32'h0);
        reset = 1'b0;

        // N=3, back-to-back bytes
        send(8'h00); send(8'h03);
        send(8'h12); send(8'h34);
        check("w0_we", 32'(mem_we), 32'h1);
        check("w0_addr", 32'(mem_Address), 32'h00);
        check("w0_data", 32'(mem_D_in), 32'h1234);
        send(8'hAB); send(8'hCD);
        send(8'h00);
        check("n3_busy_before_last", 32'(busy), 32'h1);
        check("n3_done_before_last", 32'(done), 32'h0);
        send(8'h01);
`ifdef LOADER_CHECKSUM_EN
        check("n3_done_before_chk", 32'(done), 32'h0);
        send(8'h42);
`endif
        check("n3_done", 32'(done), 32'h1);
        check("n3_cpu_reset", 32'(cpu_reset), 32'h0);
        check("n3_busy", 32'(busy), 32'h0);
        repeat (2) @(negedge clk);
        check("n3_nwrites", 32'(wr_addr.size()), 32'd3);
        if (wr_addr.size() == 3) begin
            check("n3_a0", 32'(wr_addr[0]), 32'h00);
            check("n3_d0", 32'(wr_data[0]), 32'h1234);
            check("n3_a1", 32'(wr_addr[1]), 32'h01);
            check("n3_d1", 32'(wr_data[1]), 32'hABCD);
            check("n3_a2", 32'(wr_addr[2]), 32'h02);
            check("n3_d2", 32'(wr_data[2]), 32'h0001);
        end

        // CPU owns the port in DONE
        @(posedge clk); #1;
        cpu_Address = 16'h0042; cpu_D_out = 16'hBEEF; cpu_mw_en = 1'b1;
        #1;
        check("cpu_we", 32'(mem_we), 32'h1);
        check("cpu_addr", 32'(mem_Address), 32'h42);
        check("cpu_data", 32'(mem_D_in), 32'hBEEF);
        cpu_mw_en = 1'b0;
        #1;
        check("cpu_we_low", 32'(mem_we), 32'h0);
        wr_addr.delete();
        send(8'h00); send(8'h01); send(8'h77); send(8'h88);
        repeat (2) @(negedge clk);
        check("done_rx_ignored_writes", 32'(wr_addr.size()), 32'd0);
        check("done_rx_ignored_done", 32'(done), 32'h1);

        // N=0
        do_reset();
        send(8'h00); send(8'h00);
`ifdef LOADER_CHECKSUM_EN
        check("n0_wait_chk", 32'(done), 32'h0);
        send(8'h00);
`endif
        check("n0_done", 32'(done), 32'h1);
        check("n0_cpu_reset", 32'(cpu_reset), 32'h0);
        repeat (3) @(negedge clk);
        check("n0_nwrites", 32'(wr_addr.size()), 32'd0);

        // Oversize count
        do_reset();
        send(8'h01); send(8'h01);
        check("big_error", 32'(error), 32'h1);
        check("big_cpu_reset", 32'(cpu_reset), 32'h1);
        check("big_busy", 32'(busy), 32'h0);
        check("big_done", 32'(done), 32'h0);
        send(8'h12); send(8'h34); send(8'h56); send(8'h78);
        repeat (2) @(negedge clk);
        check("big_nwrites", 32'(wr_addr.size()), 32'd0);
        check("big_error_held", 32'(error), 32'h1);

        // N=256 fills RAM exactly
        do_reset();
        ck = 8'h01;
        send(8'h01); send(8'h00);
        for (int i = 0; i < 256; i++) begin
            send(i[7:0]);
            send(~i[7:0]);
            ck = ck ^ i[7:0] ^ ~i[7:0];
        end
`ifdef LOADER_CHECKSUM_EN
        send(ck);
`endif
        check("full_done", 32'(done), 32'h1);
        check("full_error", 32'(error), 32'h0);
        repeat (2) @(negedge clk);
        check("full_nwrites", 32'(wr_addr.size()), 32'd256);
        if (wr_addr.size() == 256) begin
            check("full_first_addr", 32'(wr_addr[0]), 32'h00);
            check("full_first_data", 32'(wr_data[0]), 32'h00FF);
            check("full_last_addr", 32'(wr_addr[255]), 32'hFF);
            check("full_last_data", 32'(wr_data[255]), 32'hFF00);
        end

`ifdef LOADER_CHECKSUM_EN
        // Checksum match and mismatch
        do_reset();
        send(8'h00); send(8'h01); send(8'h00); send(8'hFF); send(8'hFE);
        check("chk_good_done", 32'(done), 32'h1);
        check("chk_good_error", 32'(error), 32'h0);
        do_reset();
        send(8'h00); send(8'h01); send(8'h00); send(8'hFF); send(8'h00);
        check("chk_bad_error", 32'(error), 32'h1);
        check("chk_bad_cpu_reset", 32'(cpu_reset), 32'h1);
`endif

        // Reset mid-load, with idle gaps between bytes
        do_reset();
        send(8'h00); send(8'h04);
        send(8'h11); @(negedge clk); send(8'h11);
        send(8'h22); repeat (2) @(negedge clk); send(8'h22);
        repeat (2) @(negedge clk);
        check("mid_nwrites", 32'(wr_addr.size()), 32'd2);
        check("mid_ram1", 32'(ram[1]), 32'h2222);
        do_reset();
        check("mid_rst_cpu_reset", 32'(cpu_reset), 32'h1);
        check("mid_rst_busy", 32'(busy), 32'h1);
        send(8'h00); @(negedge clk); send(8'h01);
        send(8'h55); send(8'h55);
`ifdef LOADER_CHECKSUM_EN
        send(8'h01);
`endif
        check("mid_done", 32'(done), 32'h1);
        repeat (2) @(negedge clk);
        check("mid_nwrites2", 32'(wr_addr.size()), 32'd1);
        check("mid_ram0", 32'(ram[0]), 32'h5555);
        check("mid_ram1_kept", 32'(ram[1]), 32'h2222);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
